// File: rtl/serial_adder_sub_if.sv
// Operand/result bundle for the serial adder/subtractor: the requester drives
// start/sub/a/b, the adder returns busy/done/sum/cout/ovf.
interface serial_adder_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_sub.sv
// Multi-cycle two's-complement adder/subtractor: BITS_PER_CYC bits per clock
// through a ripple slice, with the carry registered between slices.
module serial_adder_sub #(
    parameter int WIDTH        = 8,
    parameter int BITS_PER_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_sub_if.slave  bus
);
    localparam int K  = BITS_PER_CYC;
    localparam int N  = WIDTH / BITS_PER_CYC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_aMsb;
    logic             r_bMsb;
    logic [WIDTH-1:0] r_sum;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;

    logic [K:0]       w_slice;
    logic [WIDTH-1:0] w_sumNext;
    logic             w_lastSlice;

    assign w_slice     = {1'b0, r_a[K-1:0]} + {1'b0, r_b[K-1:0]} + {{K{1'b0}}, r_carry};
    assign w_lastSlice = (r_cnt == CW'(N - 1));

    // Slice bits enter the result from the MSB end so the low slice ends up at bit 0.
    if (K == WIDTH) begin : g_fullSlice
        assign w_sumNext = w_slice[K-1:0];
    end else begin : g_partSlice
        assign w_sumNext = {w_slice[K-1:0], r_sum[WIDTH-1:K]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_aMsb  <= 1'b0;
            r_bMsb  <= 1'b0;
            r_sum   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub;
                        r_cnt   <= '0;
                        r_aMsb  <= bus.a[WIDTH-1];
                        r_bMsb  <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> K;
                    r_b     <= r_b >> K;
                    r_sum   <= w_sumNext;
                    r_carry <= w_slice[K];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_lastSlice) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cout  <= w_slice[K];
                        r_ovf   <= (r_aMsb == r_bMsb) && (w_sumNext[WIDTH-1] != r_aMsb);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule
